// File: rtl/booth_mult6_sequencer.sv
// Operand sequencer and result collector for the 6-bit Booth multiplier.
// Buffers signed operand pairs in a DEPTH-entry FIFO, issues them one at a
// time over the start/ready handshake and captures each 12-bit product into
// a valid/ready result register.
// Optional feature: define BOOTH_SEQ_ACCUM_EN to build a 16-bit running
// signed sum of all captured products (acc_out_o); otherwise acc_out_o is 0.
module booth_mult6_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [5:0]  in_multiplicand_i,
  input  logic [5:0]  in_multiplier_i,
  output logic [5:0]  mul_multiplicand_o,
  output logic [5:0]  mul_multiplier_o,
  output logic        mul_start_o,
  input  logic        mul_ready_i,
  input  logic [11:0] mul_product_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [11:0] res_product_o,
  input  logic        acc_clr_i,
  output logic [15:0] acc_out_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

  state_e          state_q;
  logic [11:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [5:0]      mcand_q, mplier_q;
  logic            mul_start_q;
  logic            res_valid_q;
  logic [11:0]     res_product_q;
  logic            push, pop;

  // in_ready depends on count only, so a same-cycle pop never frees a full FIFO.
  assign in_ready_o = (count_q != CntW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;
  // A pop is only granted when the result register is free (or being freed),
  // which is what guarantees a later capture never overwrites a live result.
  assign pop        = (state_q == StIdle) && (count_q != '0) &&
                      (!res_valid_q || res_ready_i);

  // FIFO storage; entries need no reset since count_q gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_multiplicand_i, in_multiplier_i};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue/capture FSM with registered multiplier and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mul_start_q   <= 1'b0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
    end else begin
      if (res_valid_q && res_ready_i) res_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            {mcand_q, mplier_q} <= mem_q[rd_ptr_q];
            mul_start_q         <= 1'b1;
            state_q             <= StStart;
          end
        end
        StStart: begin
          // Wait for the multiplier to acknowledge by dropping ready.
          if (!mul_ready_i) state_q <= StBusy;
        end
        StBusy: begin
          if (mul_ready_i) begin
            res_product_q <= mul_product_i;
            res_valid_q   <= 1'b1;
            mul_start_q   <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mul_multiplicand_o = mcand_q;
  assign mul_multiplier_o   = mplier_q;
  assign mul_start_o        = mul_start_q;
  assign res_valid_o        = res_valid_q;
  assign res_product_o      = res_product_q;

`ifdef BOOTH_SEQ_ACCUM_EN
  logic [15:0] acc_q;
  logic        capture;
  logic [15:0] product_sext;

  assign capture      = (state_q == StBusy) && mul_ready_i;
  assign product_sext = {{4{mul_product_i[11]}}, mul_product_i};

  // Running sum wraps modulo 2^16; a clear coinciding with a capture keeps
  // only the new product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr_i && capture) begin
      acc_q <= product_sext;
    end else if (acc_clr_i) begin
      acc_q <= '0;
    end else if (capture) begin
      acc_q <= acc_q + product_sext;
    end
  end

  assign acc_out_o = acc_q;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr_i;
  assign acc_out_o      = '0;
`endif

endmodule

// File: tb/tb_booth_mult6_sequencer.sv
// Bench for booth_mult6_sequencer: behavioural multiplier with random latency,
// directed scenarios plus a randomized phase, results scored in FIFO order.
module tb_booth_mult6_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_multiplicand, in_multiplier;
  logic [5:0]  mul_multiplicand, mul_multiplier;
  logic        mul_start, mul_ready;
  logic [11:0] mul_product;
  logic        res_valid, res_ready;
  logic [11:0] res_product;
  logic        acc_clr;
  logic [15:0] acc_out;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [15:0] exp_acc;
  bit          rand_rr = 1'b0;
  int unsigned lat_fix = 0;
  int          op_glitch = 0;

  always #5 clk = ~clk;

  booth_mult6_sequencer #(.DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_multiplicand_i  (in_multiplicand),
    .in_multiplier_i    (in_multiplier),
    .mul_multiplicand_o (mul_multiplicand),
    .mul_multiplier_o   (mul_multiplier),
    .mul_start_o        (mul_start),
    .mul_ready_i        (mul_ready),
    .mul_product_i      (mul_product),
    .res_valid_o        (res_valid),
    .res_ready_i        (res_ready),
    .res_product_o      (res_product),
    .acc_clr_i          (acc_clr),
    .acc_out_o          (acc_out)
  );

  function automatic int sx6(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  function automatic logic [11:0] prod12(input logic [5:0] a, input logic [5:0] b);
    int p;
    p = sx6(a) * sx6(b);
    return p[11:0];
  endfunction

  function automatic logic [15:0] sext16(input logic [11:0] p);
    return {{4{p[11]}}, p};
  endfunction

  function automatic logic [15:0] acc_expect();
`ifdef BOOTH_SEQ_ACCUM_EN
    return exp_acc;
`else
    return 16'h0000;
`endif
  endfunction

  // Behavioural multiplier: latches operands on an armed start, drops ready
  // for a random number of cycles, then presents the product with ready high.
  logic        m_busy, m_armed;
  int unsigned m_cnt;
  logic [5:0]  m_a, m_b;
  logic [11:0] m_res;
  always @(posedge clk) begin
    if (rst) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      m_busy      <= 1'b0;
      m_armed     <= 1'b1;
    end else if (m_busy) begin
      if (mul_multiplicand !== m_a || mul_multiplier !== m_b) op_glitch <= op_glitch + 1;
      if (m_cnt <= 1) begin
        m_busy      <= 1'b0;
        mul_ready   <= 1'b1;
        mul_product <= m_res;
        m_armed     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (!mul_start) begin
      m_armed <= 1'b1;
    end else if (m_armed) begin
      m_busy    <= 1'b1;
      mul_ready <= 1'b0;
      m_a       <= mul_multiplicand;
      m_b       <= mul_multiplier;
      m_res     <= prod12(mul_multiplicand, mul_multiplier);
      m_cnt     <= (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
    end
  end

  // Record every completed result handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) got_q.push_back(res_product);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rr) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_op(input logic [5:0] a, input logic [5:0] b);
    int n = 0;
    in_multiplicand = a;
    in_multiplier   = b;
    in_valid        = 1'b1;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(prod12(a, b));
    exp_acc = exp_acc + sext16(prod12(a, b));
  endtask

  task automatic wait_ready(input logic lvl, input string tag);
    int n = 0;
    while (mul_ready !== lvl && n < 100) begin
      tick();
      n++;
    end
    if (mul_ready !== lvl) check(tag, 32'(mul_ready), 32'(lvl));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    int k = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check($sformatf("%s_res%0d", tag, k), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      k++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; in_valid = 1'b0; in_multiplicand = '0; in_multiplier = '0;
    res_ready = 1'b1; acc_clr = 1'b0; exp_acc = '0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mcand", 32'(mul_multiplicand), 32'd0);
    check("rst_mplier", 32'(mul_multiplier), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_product", 32'(res_product), 32'd0);
    check("rst_acc", 32'(acc_out), 32'd0);
    rst = 1'b0;
    tick();

    // Single op with issue-latency checks.
    push_op(6'd17, 6'd23);
    check("single_start_n1", 32'(mul_start), 32'd0);
    tick();
    check("single_start_n2", 32'(mul_start), 32'd1);
    check("single_mcand", 32'(mul_multiplicand), 32'd17);
    check("single_mplier", 32'(mul_multiplier), 32'd23);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_product", 32'(res_product), 32'h187);
    check("single_start_fall", 32'(mul_start), 32'd0);
    tick();
    check("single_valid_pulse", 32'(res_valid), 32'd0);
    drain("single");

    // Signed operands back to back.
    push_op(6'(-31), 6'd11);
    push_op(6'd20, 6'(-29));
    push_op(6'(-12), 6'(-13));
    drain("signed");
    check("acc_four", 32'(acc_out), 32'(acc_expect()));
`ifdef BOOTH_SEQ_ACCUM_EN
    check("acc_four_abs", 32'(acc_out), 32'hFE8A);
`endif

    // Zero operands leave the sum unchanged.
    push_op(6'd0, 6'd18);
    push_op(6'd5, 6'd0);
    drain("zero");
    check("acc_zero_ops", 32'(acc_out), 32'(acc_expect()));

    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    exp_acc = '0;
    check("acc_clr", 32'(acc_out), 32'd0);

    // Clear coinciding with a capture keeps only the new product.
    push_op(6'd7, 6'(-3));
    wait_ready(1'b0, "coinc_wait_low");
    wait_ready(1'b1, "coinc_wait_high");
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    exp_acc = sext16(prod12(6'd7, 6'(-3)));
    drain("coinc");
    check("acc_coinc", 32'(acc_out), 32'(acc_expect()));

    // Full FIFO with the result register blocked.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_rdy%0d", i), 32'(in_ready), 32'd1);
      push_op(6'($urandom), 6'($urandom));
    end
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    check("full_first_valid", 32'(res_valid), 32'd1);
    bad = 0;
    in_valid = 1'b1;
    repeat (12) begin
      tick();
      if (mul_start !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    check("full_stalled", 32'(bad), 32'd0);
    res_ready = 1'b1;
    push_op(6'($urandom), 6'($urandom));
    drain("full");
    check("acc_full", 32'(acc_out), 32'(acc_expect()));

    // Randomized traffic with random backpressure.
    rand_rr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_op(6'($urandom), 6'($urandom));
    end
    rand_rr = 1'b0;
    res_ready = 1'b1;
    drain("rand");
    check("acc_rand", 32'(acc_out), 32'(acc_expect()));

    // Reset while the multiplier is busy.
    lat_fix = 8;
    push_op(6'd9, 6'd9);
    push_op(6'd3, 6'd4);
    wait_ready(1'b0, "rst_mid_wait");
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rstmid_mul_start", 32'(mul_start), 32'd0);
    check("rstmid_res_valid", 32'(res_valid), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    lat_fix = 0;
    exp_q.delete();
    got_q.delete();
    exp_acc = '0;
    bad = 0;
    repeat (20) begin
      tick();
      if (res_valid !== 1'b0 || mul_start !== 1'b0) bad++;
    end
    check("rstmid_no_stale", 32'(bad), 32'd0);
    check("rstmid_acc", 32'(acc_out), 32'd0);
    push_op(6'(-32), 6'(-32));
    drain("post_rst");

    check("operands_stable", 32'(op_glitch), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
